// File: rtl/dw_sqrt_seq_ctl.sv
// ============================================================================
// Module   : dw_sqrt_seq_ctl
// Brief    : Iterative restoring square root, one root bit per clock, with
//            start/complete handshake, hold stall and optional signed input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dw_sqrt_seq_ctl #(
   parameter int radicand_width = 8,
   parameter int tc_mode        = 0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic                              hold,
   input  logic [radicand_width-1:0]         radicand,
   output logic                              busy,
   output logic                              complete,
   output logic [(radicand_width+1)/2-1:0]   root,
   output logic [(radicand_width+1)/2:0]     remainder,
   output logic                              neg
);

   localparam int c_r   = (radicand_width + 1) / 2;
   localparam int c_opw = 2 * c_r;
   localparam int c_cw  = (c_r > 1) ? $clog2(c_r) : 1;

   typedef enum logic [1:0] {
      st_idle = 2'd0,
      st_calc = 2'd1,
      st_done = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [c_opw-1:0]          r_op;
   logic [c_r+1:0]            r_rem;
   logic [c_r-1:0]            r_root;
   logic [c_cw-1:0]           r_cnt;
   logic                      r_neg;

   logic                      w_accept;
   logic                      w_step;
   logic                      w_last;
   logic                      w_sign;
   logic [radicand_width-1:0] w_mag;
   logic [c_r+1:0]            w_rem_sh;
   logic [c_r+1:0]            w_trial;
   logic                      w_ge;
   logic [c_r+1:0]            w_rem_nx;
   logic [c_r-1:0]            w_root_nx;

   assign w_accept = start && (r_state != st_calc);
   assign w_step   = (r_state == st_calc) && !hold;
   assign w_last   = w_step && (r_cnt == '0);

   // Negating the most negative value wraps to 2^(w-1), which is the correct
   // unsigned magnitude.
   assign w_sign = (tc_mode != 0) && radicand[radicand_width-1];
   assign w_mag  = w_sign ? (-radicand) : radicand;

   // Partial remainder never exceeds 2*root, so only its low R bits survive
   // the shift.
   assign w_rem_sh  = {c_r'(r_rem), r_op[c_opw-1 -: 2]};
   assign w_trial   = {r_root, 2'b01};
   assign w_ge      = (w_rem_sh >= w_trial);
   assign w_rem_nx  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
   assign w_root_nx = c_r'({r_root, w_ge});

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         st_idle: if (start)  w_state_next = st_calc;
         st_calc: if (w_last) w_state_next = st_done;
         st_done: w_state_next = start ? st_calc : st_idle;
         default: w_state_next = st_idle;
      endcase
   end

   assign busy     = (r_state == st_calc);
   assign complete = (r_state == st_done);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= st_idle;
         r_op      <= '0;
         r_rem     <= '0;
         r_root    <= '0;
         r_cnt     <= '0;
         r_neg     <= 1'b0;
         root      <= '0;
         remainder <= '0;
         neg       <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_op   <= c_opw'(w_mag);
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= c_cw'(c_r - 1);
            r_neg  <= w_sign;
         end else if (w_step) begin
            r_op   <= r_op << 2;
            r_rem  <= w_rem_nx;
            r_root <= w_root_nx;
            r_cnt  <= r_cnt - c_cw'(1);
            if (r_cnt == '0) begin
               root      <= w_root_nx;
               remainder <= (c_r + 1)'(w_rem_nx);
               neg       <= r_neg;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dw_sqrt_seq_ctl.sv
// ============================================================================
// Module   : tb_dw_sqrt_seq_ctl
// Brief    : Directed and random checks of dw_sqrt_seq_ctl at several widths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dw_sqrt_seq_ctl;

   logic       clk = 1'b0;
   logic       rst, start, hold;
   logic [8:0] x;

   logic       b8, c8, n8;   logic [3:0] rt8;  logic [4:0] rm8;
   logic       b8t, c8t, n8t; logic [3:0] rt8t; logic [4:0] rm8t;
   logic       b7, c7, n7;   logic [3:0] rt7;  logic [4:0] rm7;
   logic       b9, c9, n9;   logic [4:0] rt9;  logic [5:0] rm9;
   logic       b9t, c9t, n9t; logic [4:0] rt9t; logic [5:0] rm9t;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dw_sqrt_seq_ctl #(.radicand_width(8), .tc_mode(0)) u8 (
      .clk(clk), .rst(rst), .start(start), .hold(hold), .radicand(x[7:0]),
      .busy(b8), .complete(c8), .root(rt8), .remainder(rm8), .neg(n8));
   dw_sqrt_seq_ctl #(.radicand_width(8), .tc_mode(1)) u8t (
      .clk(clk), .rst(rst), .start(start), .hold(hold), .radicand(x[7:0]),
      .busy(b8t), .complete(c8t), .root(rt8t), .remainder(rm8t), .neg(n8t));
   dw_sqrt_seq_ctl #(.radicand_width(7), .tc_mode(0)) u7 (
      .clk(clk), .rst(rst), .start(start), .hold(hold), .radicand(x[6:0]),
      .busy(b7), .complete(c7), .root(rt7), .remainder(rm7), .neg(n7));
   dw_sqrt_seq_ctl #(.radicand_width(9), .tc_mode(0)) u9 (
      .clk(clk), .rst(rst), .start(start), .hold(hold), .radicand(x),
      .busy(b9), .complete(c9), .root(rt9), .remainder(rm9), .neg(n9));
   dw_sqrt_seq_ctl #(.radicand_width(9), .tc_mode(1)) u9t (
      .clk(clk), .rst(rst), .start(start), .hold(hold), .radicand(x),
      .busy(b9t), .complete(c9t), .root(rt9t), .remainder(rm9t), .neg(n9t));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int mag(input int v, input int w, input bit tc);
      if (tc && v >= (1 << (w - 1))) return (1 << w) - v;
      return v;
   endfunction

   function automatic int isqrt(input int m);
      int r = 0;
      while ((r + 1) * (r + 1) <= m) r++;
      return r;
   endfunction

   task automatic chk_res(input string tag, input int m, input logic [63:0] rt,
                          input logic [63:0] rm, input logic ng, input logic eng);
      int r;
      r = isqrt(m);
      chk({tag, "_root"}, rt, 64'(r));
      chk({tag, "_rem"}, rm, 64'(m - r * r));
      chk({tag, "_rem_le_2root"}, 64'(rm <= 2 * rt), 64'd1);
      chk({tag, "_neg"}, 64'(ng), 64'(eng));
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int n;
      int lat;
      int m8, m8t, m9, m9t;
      bit s8, s8t, s9, s9t;
      bit p8, p8t, p9, p9t;
      rst = 1'b1; start = 1'b0; hold = 1'b0; x = '0;
      tick(); tick();
      chk("rst_busy", 64'(b8), 0);
      chk("rst_complete", 64'(c8), 0);
      chk("rst_root", 64'(rt8), 0);
      chk("rst_rem", 64'(rm8), 0);
      chk("rst_neg", 64'(n8t), 0);
      rst = 1'b0;
      tick();

      // 200 unsigned: busy for 4 cycles, then complete
      x = 9'd200; start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (b8 === 1'b1 && n < 30) begin tick(); n++; end
      chk("t200_busy_cycles", 64'(n), 4);
      chk("t200_complete", 64'(c8), 1);
      chk("t200_root", 64'(rt8), 14);
      chk("t200_rem", 64'(rm8), 4);
      chk("t200_neg", 64'(n8), 0);
      chk("t200_tc_root", 64'(rt8t), 7);
      chk("t200_tc_rem", 64'(rm8t), 7);
      chk("t200_tc_neg", 64'(n8t), 1);
      chk("t200_w7_root", 64'(rt7), 8);
      chk("t200_w7_rem", 64'(rm7), 8);
      tick();
      chk("t200_complete_pulse", 64'(c8), 0);
      settle(3);

      // 255 then 0 back-to-back
      x = 9'd255; start = 1'b1; tick(); start = 1'b0;
      chk("b2b_busy", 64'(b8), 1);
      chk("b2b_prev_root_held", 64'(rt8), 14);
      n = 0;
      while (c8 !== 1'b1 && n < 30) begin tick(); n++; end
      chk("b2b_first_lat", 64'(n), 4);
      chk("b2b_255_root", 64'(rt8), 15);
      chk("b2b_255_rem", 64'(rm8), 30);
      chk("b2b_m1_root", 64'(rt8t), 1);
      chk("b2b_m1_neg", 64'(n8t), 1);
      x = 9'd0; start = 1'b1; tick(); start = 1'b0;
      chk("b2b_no_gap", 64'(b8), 1);
      n = 0;
      while (c8 !== 1'b1 && n < 30) begin tick(); n++; end
      chk("b2b_second_lat", 64'(n), 4);
      chk("b2b_0_root", 64'(rt8), 0);
      chk("b2b_0_rem", 64'(rm8), 0);
      chk("b2b_0_neg", 64'(n8t), 0);
      tick();
      chk("b2b_complete_pulse", 64'(c8), 0);
      settle(4);

      // two's complement: -128 and -9
      x = 9'h080; start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (c8t !== 1'b1 && n < 30) begin tick(); n++; end
      chk("tc_m128_root", 64'(rt8t), 11);
      chk("tc_m128_rem", 64'(rm8t), 7);
      chk("tc_m128_neg", 64'(n8t), 1);
      chk("u_128_root", 64'(rt8), 11);
      settle(3);
      x = 9'h0F7; start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (c8t !== 1'b1 && n < 30) begin tick(); n++; end
      chk("tc_m9_root", 64'(rt8t), 3);
      chk("tc_m9_rem", 64'(rm8t), 0);
      chk("tc_m9_neg", 64'(n8t), 1);
      chk("u_247_root", 64'(rt8), 15);
      chk("u_247_rem", 64'(rm8), 22);
      chk("u_247_neg", 64'(n8), 0);
      settle(3);

      // odd width 7, then the same operation with 3 held cycles
      x = 9'd127; start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (c7 !== 1'b1 && n < 30) begin tick(); n++; end
      chk("w7_lat", 64'(n), 4);
      chk("w7_root", 64'(rt7), 11);
      chk("w7_rem", 64'(rm7), 6);
      settle(4);
      start = 1'b1; tick(); start = 1'b0;
      tick();
      hold = 1'b1;
      settle(3);
      chk("hold_busy", 64'(b7), 1);
      chk("hold_no_complete", 64'(c7), 0);
      hold = 1'b0;
      n = 0;
      while (c7 !== 1'b1 && n < 30) begin tick(); n++; end
      lat = 4 + n;
      chk("hold_lat", 64'(lat), 7);
      chk("hold_root", 64'(rt7), 11);
      chk("hold_rem", 64'(rm7), 6);
      settle(4);

      // start while busy is ignored
      x = 9'd100; start = 1'b1; tick(); start = 1'b0;
      tick();
      x = 9'd4; start = 1'b1; tick(); start = 1'b0;
      chk("ign_busy", 64'(b8), 1);
      n = 0;
      while (c8 !== 1'b1 && n < 30) begin tick(); n++; end
      chk("ign_lat", 64'(n), 2);
      chk("ign_root", 64'(rt8), 10);
      chk("ign_rem", 64'(rm8), 0);
      settle(4);

      // reset mid-operation
      x = 9'd200; start = 1'b1; tick(); start = 1'b0;
      tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk("abort_busy", 64'(b8), 0);
      chk("abort_complete", 64'(c8), 0);
      chk("abort_root", 64'(rt8), 0);
      chk("abort_rem", 64'(rm8), 0);
      chk("abort_tc_neg", 64'(n8t), 0);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (c8 === 1'b1 || c8t === 1'b1) n++;
      end
      chk("abort_no_complete", 64'(n), 0);

      // random sweep on widths 8 and 9, both modes
      for (int i = 0; i < 30; i++) begin
         x = 9'($urandom_range(0, 511));
         m8  = mag(int'(x[7:0]), 8, 1'b0);
         m8t = mag(int'(x[7:0]), 8, 1'b1);
         m9  = mag(int'(x), 9, 1'b0);
         m9t = mag(int'(x), 9, 1'b1);
         start = 1'b1; tick(); start = 1'b0;
         s8 = 0; s8t = 0; s9 = 0; s9t = 0;
         p8 = 0; p8t = 0; p9 = 0; p9t = 0;
         for (int k = 0; k < 10; k++) begin
            if (c8 === 1'b1)  begin s8 = 1;  chk_res("rnd_w8", m8, 64'(rt8), 64'(rm8), n8, 1'b0); end
            if (c8t === 1'b1) begin s8t = 1; chk_res("rnd_w8tc", m8t, 64'(rt8t), 64'(rm8t), n8t, x[7]); end
            if (c9 === 1'b1)  begin s9 = 1;  chk_res("rnd_w9", m9, 64'(rt9), 64'(rm9), n9, 1'b0); end
            if (c9t === 1'b1) begin s9t = 1; chk_res("rnd_w9tc", m9t, 64'(rt9t), 64'(rm9t), n9t, x[8]); end
            chk("rnd_complete_twice", 64'((p8 & c8) | (p8t & c8t) | (p9 & c9) | (p9t & c9t)), 0);
            p8 = c8; p8t = c8t; p9 = c9; p9t = c9t;
            tick();
         end
         chk("rnd_seen", 64'({s8, s8t, s9, s9t}), 64'hF);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
